wolfram_ca_engine: RTL and testbench

//   Sequential 1-D elementary cellular-automaton engine. Holds a WIDTH-cell ring and

---
 rtl/wolfram_ca_engine.sv | 127 ++++++++++++
 tb/tb_wolfram_ca_engine.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wolfram_ca_engine.sv
// wolfram_ca_engine: programmable 1-D elementary cellular automaton on a WIDTH-cell ring.
// A start in IDLE latches seed/rule/steps. The engine then computes one generation
// per clock until the requested count is reached, or until abort.
// Optional feature macro: CA_CYCLE_DETECT_EN adds the fixed_pt output. With it,
// a run stops early when the next generation equals the current one.
module wolfram_ca_engine #(
   parameter int WIDTH  = 16,
   parameter int STEP_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [7:0]        rule,
   input  logic [WIDTH-1:0]  seed,
   input  logic [STEP_W-1:0] steps,
   output logic [WIDTH-1:0]  cells,
   output logic [STEP_W-1:0] gen_cnt,
   output logic              busy,
   output logic              done
`ifdef CA_CYCLE_DETECT_EN
   ,
   output logic              fixed_pt
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [STEP_W-1:0] ONE = 1;

   state_t            state;
   state_t            state_next;
   logic [7:0]        rule_lat;
   logic [STEP_W-1:0] steps_lat;
   logic [WIDTH-1:0]  next_cells;
   logic [STEP_W-1:0] gen_inc;
   logic              load;
   logic              advance;
`ifdef CA_CYCLE_DETECT_EN
   logic              hit_fixed;
`endif

   assign gen_inc = gen_cnt + ONE;
   assign busy    = (state == RUN);
   assign done    = (state == DONE);

   // Next generation: each cell indexes the rule with {left, centre, right}, bit-reversed (7 - pattern)
   always_comb begin
      logic [2:0] pattern;
      pattern    = 3'd0;
      next_cells = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pattern       = {cells[(i + 1) % WIDTH], cells[i], cells[(i + WIDTH - 1) % WIDTH]};
         next_cells[i] = rule_lat[3'd7 - pattern];
      end
   end

   // State register, reset synchronously to IDLE
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state and datapath strobes; abort has priority over the final update
   always_comb begin
      state_next = state;
      load       = 1'b0;
      advance    = 1'b0;
`ifdef CA_CYCLE_DETECT_EN
      hit_fixed  = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = (steps == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_next = IDLE;
`ifdef CA_CYCLE_DETECT_EN
            end else if (next_cells == cells) begin
               hit_fixed  = 1'b1;
               state_next = DONE;
`endif
            end else begin
               advance = 1'b1;
               if (gen_inc == steps_lat) state_next = DONE;
            end
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Generation, counter and latched run parameters; values hold unless loading or advancing
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cells     <= '0;
         gen_cnt   <= '0;
         rule_lat  <= '0;
         steps_lat <= '0;
      end else if (load) begin
         cells     <= seed;
         gen_cnt   <= '0;
         rule_lat  <= rule;
         steps_lat <= steps;
      end else if (advance) begin
         cells     <= next_cells;
         gen_cnt   <= gen_inc;
      end
   end

`ifdef CA_CYCLE_DETECT_EN
   // Fixed-point flag is high only during the DONE cycle that a detected fixed point caused
   always_ff @(posedge clk) begin
      if (!rst_n) fixed_pt <= 1'b0;
      else        fixed_pt <= hit_fixed;
   end
`endif

endmodule

// File: tb/tb_wolfram_ca_engine.sv
// tb_wolfram_ca_engine: directed checks of the CA engine with WIDTH=8.
// Expected generations are hand-derived from next[i] = rule[7 - {L,C,R}].
module tb_wolfram_ca_engine;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [7:0] rule;
   logic [7:0] seed;
   logic [7:0] steps;
   logic [7:0] cells;
   logic [7:0] gen_cnt;
   logic       busy;
   logic       done;
`ifdef CA_CYCLE_DETECT_EN
   logic       fixed_pt;
`endif

   int errors = 0;
   int checks = 0;

   wolfram_ca_engine #(.WIDTH(8), .STEP_W(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .abort   (abort),
      .rule    (rule),
      .seed    (seed),
      .steps   (steps),
      .cells   (cells),
      .gen_cnt (gen_cnt),
      .busy    (busy),
      .done    (done)
`ifdef CA_CYCLE_DETECT_EN
      ,
      .fixed_pt(fixed_pt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic launch(input logic [7:0] r, input logic [7:0] s, input logic [7:0] n);
      rule  = r;
      seed  = s;
      steps = n;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      rule  = 8'h00;
      seed  = 8'h00;
      steps = 8'h00;
      tick();
      tick();
      check("reset cells", cells, 8'h00);
      check("reset gen_cnt", gen_cnt, 8'h00);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
`ifdef CA_CYCLE_DETECT_EN
      check("reset fixed_pt", fixed_pt, 1'b0);
`endif
      rst_n = 1'b1;
      tick();

      // rule 0x1D, seed 0x01, three generations
      launch(8'h1D, 8'h01, 8'd3);
      seed = 8'hFF;
      rule = 8'h00;
      check("r1D T+1 cells", cells, 8'h01);
      check("r1D T+1 busy", busy, 1'b1);
      check("r1D T+1 gen", gen_cnt, 8'd0);
      tick();
      check("r1D T+2 cells", cells, 8'h80);
      tick();
      check("r1D T+3 cells", cells, 8'h40);
      check("r1D T+3 done", done, 1'b0);
      tick();
      check("r1D T+4 cells", cells, 8'h20);
      check("r1D T+4 gen", gen_cnt, 8'd3);
      check("r1D T+4 done", done, 1'b1);
      check("r1D T+4 busy", busy, 1'b0);
      tick();
      check("r1D T+5 done", done, 1'b0);
      check("r1D T+5 hold", cells, 8'h20);

      // zero steps: immediate done, never busy
      launch(8'h1D, 8'hA5, 8'd0);
      check("zero T+1 cells", cells, 8'hA5);
      check("zero T+1 done", done, 1'b1);
      check("zero T+1 busy", busy, 1'b0);
      tick();
      check("zero T+2 done", done, 1'b0);
      check("zero T+2 busy", busy, 1'b0);

      // start held during RUN with a new seed is ignored
      launch(8'h1D, 8'h01, 8'd4);
      seed  = 8'h55;
      start = 1'b1;
      tick();
      check("restart T+2 cells", cells, 8'h80);
      tick();
      check("restart T+3 cells", cells, 8'h40);
      tick();
      start = 1'b0;
      check("restart T+4 cells", cells, 8'h20);
      tick();
      check("restart T+5 cells", cells, 8'h10);
      check("restart T+5 gen", gen_cnt, 8'd4);
      check("restart T+5 done", done, 1'b1);
      tick();

      // abort mid-run
      launch(8'h1D, 8'h01, 8'd6);
      tick();
      tick();
      check("abort T+3 gen", gen_cnt, 8'd2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort T+4 busy", busy, 1'b0);
      check("abort T+4 done", done, 1'b0);
      check("abort T+4 gen", gen_cnt, 8'd2);
      check("abort T+4 cells", cells, 8'h40);
      tick();
      check("abort T+5 done", done, 1'b0);
      check("abort T+5 hold", cells, 8'h40);

      // abort on the same edge as the final update wins
      launch(8'h1D, 8'h01, 8'd2);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abortlast cells", cells, 8'h80);
      check("abortlast gen", gen_cnt, 8'd1);
      check("abortlast done", done, 1'b0);
      check("abortlast busy", busy, 1'b0);
      tick();

      // synchronous reset mid-run
      launch(8'h1D, 8'h01, 8'd10);
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      check("midreset cells", cells, 8'h00);
      check("midreset busy", busy, 1'b0);
      check("midreset gen", gen_cnt, 8'd0);
      check("midreset done", done, 1'b0);
      rst_n = 1'b1;
      tick();
      check("midreset idle", busy, 1'b0);

      // rule 0xF0: next[i] = ~cells[i+1]
      launch(8'hF0, 8'h0F, 8'd1);
      tick();
      check("rF0 cells", cells, 8'h78);
      check("rF0 done", done, 1'b1);
      check("rF0 gen", gen_cnt, 8'd1);
      tick();

      // rule 0xFF from all-zero: becomes a fixed point after one generation
      launch(8'hFF, 8'h00, 8'd5);
      tick();
      check("rFF T+2 cells", cells, 8'hFF);
      tick();
`ifdef CA_CYCLE_DETECT_EN
      check("rFF T+3 done", done, 1'b1);
      check("rFF T+3 fixed_pt", fixed_pt, 1'b1);
      check("rFF T+3 gen", gen_cnt, 8'd1);
      check("rFF T+3 cells", cells, 8'hFF);
      tick();
      check("rFF T+4 fixed_pt", fixed_pt, 1'b0);
      check("rFF T+4 done", done, 1'b0);
`else
      check("rFF T+3 done", done, 1'b0);
      tick();
      tick();
      check("rFF T+5 done", done, 1'b0);
      tick();
      check("rFF T+6 done", done, 1'b1);
      check("rFF T+6 gen", gen_cnt, 8'd5);
      check("rFF T+6 cells", cells, 8'hFF);
`endif
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
